// File: rtl/ec_pkg.sv
// Shared types and defaults for the elite tracker. The default lattice/fitness
// sizes are the same ones fitness_eval uses.
package ec_pkg;
    localparam int DATA_WIDTH_DEF      = 4;
    localparam int LATTICE_LENGTH_DEF  = 11;
    localparam int SELF_FIT_LENGTH_DEF = 10;
    localparam int POP_SIZE_DEF        = 8;
    localparam int GEN_WIDTH_DEF       = 8;
    localparam int STALL_LIMIT_DEF     = 4;

    localparam logic [SELF_FIT_LENGTH_DEF-1:0] FIT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_REPORT
    } ec_state_e;

    function automatic int idx_width(input int pop);
        return (pop < 2) ? 1 : $clog2(pop);
    endfunction

    localparam int IDX_WIDTH_DEF = idx_width(POP_SIZE_DEF);
endpackage

// File: rtl/fit_min_cmp.sv
// Registered keep-the-minimum slot: holds {fit, tag, vec} and replaces it when
// the candidate is strictly lower (ties keep the older entry) or when forced.
module fit_min_cmp #(
    parameter int FIT_W = 10,
    parameter int TAG_W = 3,
    parameter int VEC_W = 44
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             init_i,
    input  logic             en_i,
    input  logic             force_i,
    input  logic [FIT_W-1:0] fit_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [VEC_W-1:0] vec_i,
    output logic [FIT_W-1:0] fit_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [VEC_W-1:0] vec_o
);
    logic [FIT_W-1:0] fit_q;
    logic [TAG_W-1:0] tag_q;
    logic [VEC_W-1:0] vec_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fit_q <= '1;
            tag_q <= '0;
            vec_q <= '0;
        end else if (init_i) begin
            fit_q <= '1;
            tag_q <= '0;
            vec_q <= '0;
        end else if (en_i && (force_i || (fit_i < fit_q))) begin
            fit_q <= fit_i;
            tag_q <= tag_i;
            vec_q <= vec_i;
        end
    end

    assign fit_o = fit_q;
    assign tag_o = tag_q;
    assign vec_o = vec_q;
endmodule

// File: rtl/elite_tracker.sv
// Tracks per-generation and global minimum-fitness individuals, generation and
// stagnation counters, and a sticky converge flag. FITNESS_SUM_EN adds gen_fit_sum_o.
module elite_tracker
    import ec_pkg::*;
#(
    parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int LATTICE_LENGTH    = LATTICE_LENGTH_DEF,
    parameter int SELF_FIT_LENGTH   = SELF_FIT_LENGTH_DEF,
    parameter int INDIVIDUAL_LENGTH = LATTICE_LENGTH * DATA_WIDTH,
    parameter int POP_SIZE          = POP_SIZE_DEF,
    parameter int IDX_WIDTH         = idx_width(POP_SIZE),
    parameter int GEN_WIDTH         = GEN_WIDTH_DEF,
    parameter int STALL_LIMIT       = STALL_LIMIT_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         clear_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [SELF_FIT_LENGTH-1:0]   self_fit_i,
    input  logic [INDIVIDUAL_LENGTH-1:0] individual_vec_i,
    output logic                         gen_done_o,
    output logic [SELF_FIT_LENGTH-1:0]   gen_best_fit_o,
    output logic [IDX_WIDTH-1:0]         gen_best_idx_o,
    output logic [SELF_FIT_LENGTH-1:0]   best_fit_o,
    output logic [INDIVIDUAL_LENGTH-1:0] best_ind_o,
    output logic [GEN_WIDTH-1:0]         best_gen_o,
    output logic [GEN_WIDTH-1:0]         gen_cnt_o,
    output logic [GEN_WIDTH-1:0]         stall_cnt_o,
`ifdef FITNESS_SUM_EN
    output logic [SELF_FIT_LENGTH+IDX_WIDTH:0] gen_fit_sum_o,
`endif
    output logic                         converge_o
);
    // rst_n is active-high despite its name
    logic rst;
    assign rst = rst_n;

    ec_state_e state_q, state_d;
    logic [IDX_WIDTH-1:0]       cnt_q, cnt_d;
    logic [GEN_WIDTH-1:0]       gen_cnt_q, gen_cnt_d;
    logic [GEN_WIDTH-1:0]       stall_q, stall_d;
    logic                       conv_q, conv_d;
    logic                       elite_valid_q, elite_valid_d;
    logic [SELF_FIT_LENGTH-1:0] gen_best_fit_q, gen_best_fit_d;
    logic [IDX_WIDTH-1:0]       gen_best_idx_q, gen_best_idx_d;

    logic [SELF_FIT_LENGTH-1:0]   run_fit, elite_fit;
    logic [IDX_WIDTH-1:0]         run_idx;
    logic [INDIVIDUAL_LENGTH-1:0] run_vec;

    logic accept, do_clear, do_start, in_report, improved;
    logic [GEN_WIDTH-1:0] stall_nxt;

    assign in_ready_o = (state_q == ST_COLLECT);
    assign in_report  = (state_q == ST_REPORT);
    assign accept     = in_valid_i & in_ready_o;
    assign do_clear   = (state_q == ST_IDLE) & clear_i;
    assign do_start   = (state_q == ST_IDLE) & ~clear_i & start_i;
    assign improved   = ~elite_valid_q | (run_fit < elite_fit);
    assign stall_nxt  = improved ? '0 : ((stall_q == '1) ? stall_q : stall_q + 1'b1);

    // Running best of the current generation; the first accept always loads.
    fit_min_cmp #(
        .FIT_W (SELF_FIT_LENGTH),
        .TAG_W (IDX_WIDTH),
        .VEC_W (INDIVIDUAL_LENGTH)
    ) u_run_best (
        .clk_i   (clk_i),
        .rst_i   (rst),
        .init_i  (do_start),
        .en_i    (accept),
        .force_i (cnt_q == '0),
        .fit_i   (self_fit_i),
        .tag_i   (cnt_q),
        .vec_i   (individual_vec_i),
        .fit_o   (run_fit),
        .tag_o   (run_idx),
        .vec_o   (run_vec)
    );

    // Global elite; the tag slot carries the generation it was found in.
    fit_min_cmp #(
        .FIT_W (SELF_FIT_LENGTH),
        .TAG_W (GEN_WIDTH),
        .VEC_W (INDIVIDUAL_LENGTH)
    ) u_elite (
        .clk_i   (clk_i),
        .rst_i   (rst),
        .init_i  (do_clear),
        .en_i    (in_report),
        .force_i (~elite_valid_q),
        .fit_i   (run_fit),
        .tag_i   (gen_cnt_q),
        .vec_i   (run_vec),
        .fit_o   (elite_fit),
        .tag_o   (best_gen_o),
        .vec_o   (best_ind_o)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        gen_cnt_d      = gen_cnt_q;
        stall_d        = stall_q;
        conv_d         = conv_q;
        elite_valid_d  = elite_valid_q;
        gen_best_fit_d = gen_best_fit_q;
        gen_best_idx_d = gen_best_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    gen_cnt_d     = '0;
                    stall_d       = '0;
                    conv_d        = 1'b0;
                    elite_valid_d = 1'b0;
                end else if (start_i) begin
                    cnt_d   = '0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == IDX_WIDTH'(POP_SIZE - 1)) state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                gen_best_fit_d = run_fit;
                gen_best_idx_d = run_idx;
                stall_d        = stall_nxt;
                elite_valid_d  = 1'b1;
                gen_cnt_d      = (gen_cnt_q == '1) ? gen_cnt_q : gen_cnt_q + 1'b1;
                conv_d         = conv_q | (stall_nxt >= GEN_WIDTH'(STALL_LIMIT));
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            gen_cnt_q      <= '0;
            stall_q        <= '0;
            conv_q         <= 1'b0;
            elite_valid_q  <= 1'b0;
            gen_best_fit_q <= '1;
            gen_best_idx_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            gen_cnt_q      <= gen_cnt_d;
            stall_q        <= stall_d;
            conv_q         <= conv_d;
            elite_valid_q  <= elite_valid_d;
            gen_best_fit_q <= gen_best_fit_d;
            gen_best_idx_q <= gen_best_idx_d;
        end
    end

`ifdef FITNESS_SUM_EN
    localparam int SUM_W = SELF_FIT_LENGTH + IDX_WIDTH + 1;
    logic [SUM_W-1:0] acc_q, acc_d, sum_q;

    always_comb begin
        acc_d = acc_q;
        if (do_start)    acc_d = '0;
        else if (accept) acc_d = acc_q + SUM_W'(self_fit_i);
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (in_report) sum_q <= acc_q;
        end
    end

    assign gen_fit_sum_o = sum_q;
`endif

    assign gen_done_o     = in_report;
    assign gen_best_fit_o = gen_best_fit_q;
    assign gen_best_idx_o = gen_best_idx_q;
    assign best_fit_o     = elite_fit;
    assign gen_cnt_o      = gen_cnt_q;
    assign stall_cnt_o    = stall_q;
    assign converge_o     = conv_q;
endmodule
